// File: rtl/ee_prog_sched_if.sv
// Purpose : request/grant, engine and status bundle of the ee_prog_module scheduler.
// Latency : wiring only; no state lives here.
// Backpr. : requesters hold *_vld until the matching one-cycle *_ack.
// Ports   : req0_* = SPI page/byte-write commit, req1_* = trim/config rewrite,
//           cfg_* = per-operation options, ee_* = HV engine side, busy/done*/err = status.
//           slave = scheduler view, master = requester/engine view.
interface ee_prog_sched_if #(
    parameter int ROW_W = 6
);
    logic             req0_vld;
    logic [ROW_W-1:0] req0_row;
    logic [3:0]       req0_nrow;
    logic             req1_vld;
    logic [ROW_W-1:0] req1_row;
    logic [3:0]       req1_nrow;
    logic             req0_ack;
    logic             req1_ack;
    logic [1:0]       cfg_pump_opt;
    logic [1:0]       cfg_ramp_opt;
    logic             abort;
    logic             ee_wdone;
    logic             ee_wbusy_s;
    logic [ROW_W-1:0] ee_row;
    logic [1:0]       ee_pump_opt;
    logic [1:0]       ee_ramp_opt;
    logic             busy;
    logic             done0;
    logic             done1;
    logic             err;

    modport slave (
        input  req0_vld, req0_row, req0_nrow,
        input  req1_vld, req1_row, req1_nrow,
        input  cfg_pump_opt, cfg_ramp_opt, abort, ee_wdone,
        output req0_ack, req1_ack,
        output ee_wbusy_s, ee_row, ee_pump_opt, ee_ramp_opt,
        output busy, done0, done1, err
    );

    modport master (
        output req0_vld, req0_row, req0_nrow,
        output req1_vld, req1_row, req1_nrow,
        output cfg_pump_opt, cfg_ramp_opt, abort, ee_wdone,
        input  req0_ack, req1_ack,
        input  ee_wbusy_s, ee_row, ee_pump_opt, ee_ramp_opt,
        input  busy, done0, done1, err
    );
endinterface

// File: rtl/ee_prog_sched.sv
// Purpose : arbitrates SPI-write (req0) and trim-rewrite (req1) onto the single HV program engine, row by row.
// Latency : grant -> ee_wbusy_s rise SETUP_CYC+1; ee_wdone -> next row rise RECOV_CYC+SETUP_CYC+2; last ee_wdone -> done RECOV_CYC+2.
// Backpr. : requests are only looked at in IDLE; a requester holds vld until its ack, the loser simply waits.
// Ports   : timer_clk, sys_rst (synchronous, active high), bus = ee_prog_sched_if.slave
//           (request/ack pairs, cfg options, abort, engine handshake ee_wbusy_s/ee_wdone, status busy/done0/done1/err).
module ee_prog_sched #(
    parameter int ROW_W     = 6,
    parameter int SETUP_CYC = 4,
    parameter int RECOV_CYC = 8,
    parameter int TOUT_CYC  = 4095
) (
    input  logic           timer_clk,
    input  logic           sys_rst,
    ee_prog_sched_if.slave bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_PROG   = 3'd2;
    localparam logic [2:0] S_RECOV  = 3'd3;
    localparam logic [2:0] S_NEXT   = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    localparam logic [11:0] SETUP_LAST = 12'(SETUP_CYC - 1);
    localparam logic [11:0] RECOV_LAST = 12'(RECOV_CYC - 1);
    localparam logic [11:0] TOUT_LAST  = 12'(TOUT_CYC - 1);

    logic [2:0]       state;
    logic [11:0]      cnt;
    logic [3:0]       rows_left;
    logic [ROW_W-1:0] row_q;
    logic [1:0]       pump_q;
    logic [1:0]       ramp_q;
    logic             owner;
    logic             last_grant;
    logic             err_lat;
    logic             gnt0;
    logic             gnt1;

    // Round-robin: on a tie the requester not served last wins. last_grant
    // resets to 1 so req0 takes the first tie.
    assign gnt0 = (state == S_IDLE) && !sys_rst && bus.req0_vld &&
                  (!bus.req1_vld || last_grant);
    assign gnt1 = (state == S_IDLE) && !sys_rst && bus.req1_vld &&
                  (!bus.req0_vld || !last_grant);

    always_ff @(posedge timer_clk) begin
        if (sys_rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            rows_left  <= '0;
            row_q      <= '0;
            pump_q     <= '0;
            ramp_q     <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            err_lat    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (gnt0 || gnt1) begin
                        row_q      <= gnt1 ? bus.req1_row : bus.req0_row;
                        rows_left  <= gnt1 ? bus.req1_nrow : bus.req0_nrow;
                        pump_q     <= bus.cfg_pump_opt;
                        ramp_q     <= bus.cfg_ramp_opt;
                        owner      <= gnt1;
                        last_grant <= gnt1;
                        cnt        <= '0;
                        state      <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (bus.abort) begin
                        err_lat <= 1'b1;
                        state   <= S_FINISH;
                    end else if (cnt == SETUP_LAST) begin
                        cnt   <= '0;
                        state <= S_PROG;
                    end else begin
                        cnt <= cnt + 12'd1;
                    end
                end
                S_PROG: begin
                    // ee_wdone is checked before the timeout so a completion
                    // landing on the last allowed cycle is not an error.
                    if (bus.abort) begin
                        err_lat <= 1'b1;
                        state   <= S_FINISH;
                    end else if (bus.ee_wdone) begin
                        cnt   <= '0;
                        state <= S_RECOV;
                    end else if (cnt == TOUT_LAST) begin
                        err_lat <= 1'b1;
                        state   <= S_FINISH;
                    end else begin
                        cnt <= cnt + 12'd1;
                    end
                end
                S_RECOV: begin
                    // Low gap long enough for the engine's 2-flop sync to see
                    // ee_wbusy_s fall before the next rise.
                    if (bus.abort) begin
                        err_lat <= 1'b1;
                        state   <= S_FINISH;
                    end else if (cnt == RECOV_LAST) begin
                        cnt   <= '0;
                        state <= S_NEXT;
                    end else begin
                        cnt <= cnt + 12'd1;
                    end
                end
                S_NEXT: begin
                    if (rows_left == 4'd0) begin
                        state <= S_FINISH;
                    end else begin
                        rows_left <= rows_left - 4'd1;
                        row_q     <= row_q + 1'b1;
                        cnt       <= '0;
                        state     <= S_SETUP;
                    end
                end
                S_FINISH: begin
                    err_lat <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req0_ack    = gnt0;
    assign bus.req1_ack    = gnt1;
    assign bus.ee_wbusy_s  = (state == S_PROG);
    assign bus.ee_row      = row_q;
    assign bus.ee_pump_opt = pump_q;
    assign bus.ee_ramp_opt = ramp_q;
    assign bus.busy        = (state != S_IDLE);
    assign bus.done0       = (state == S_FINISH) && !owner;
    assign bus.done1       = (state == S_FINISH) && owner;
    assign bus.err         = (state == S_FINISH) && err_lat;
endmodule

// File: tb/tb_ee_prog_sched.sv
module tb_ee_prog_sched;
    localparam int ROW_W     = 6;
    localparam int SETUP_CYC = 4;
    localparam int RECOV_CYC = 8;
    localparam int TOUT_CYC  = 4095;

    logic timer_clk = 1'b0;
    logic sys_rst;
    always #5 timer_clk = ~timer_clk;

    ee_prog_sched_if #(.ROW_W(ROW_W)) bus ();

    ee_prog_sched #(
        .ROW_W    (ROW_W),
        .SETUP_CYC(SETUP_CYC),
        .RECOV_CYC(RECOV_CYC),
        .TOUT_CYC (TOUT_CYC)
    ) dut (
        .timer_clk(timer_clk),
        .sys_rst  (sys_rst),
        .bus      (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int m_last  = 1;   // model: requester granted last (1 after reset)

    task automatic check(input string tag, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // One cycle: sample/drive point is 3 time units after the rising edge.
    task automatic step();
        @(posedge timer_clk);
        #3;
        cyc++;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_wbusy"}, int'(bus.ee_wbusy_s), 0);
        check({tag, "_busy"},  int'(bus.busy), 0);
        check({tag, "_done0"}, int'(bus.done0), 0);
        check({tag, "_done1"}, int'(bus.done1), 0);
        check({tag, "_err"},   int'(bus.err), 0);
        check({tag, "_row"},   int'(bus.ee_row), 0);
        check({tag, "_pump"},  int'(bus.ee_pump_opt), 0);
        check({tag, "_ramp"},  int'(bus.ee_ramp_opt), 0);
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        step();
        step();
        sys_rst = 1'b0;
        m_last  = 1;
        #1;
        check_quiet("rst");
        check("rst_ack0", int'(bus.req0_ack), 0);
        check("rst_ack1", int'(bus.req1_ack), 0);
    endtask

    // Serves one operation from IDLE. Expectations come from the timing
    // rules: first rise SETUP+1 after grant, each later rise
    // RECOV+SETUP+2 after the previous ee_wdone, done RECOV+2 after the
    // last ee_wdone, abort/timeout -> done in the cycle ee_wbusy_s drops.
    // Row index equal to tout_row/abort_row/rst_row selects that fault.
    task automatic serve(input int wd_fix, input int tout_row, input int abort_row,
                         input int abort_off, input int rst_row);
        int w, g, c, n, d, exp_done, exp_err;
        bit ended;
        logic [ROW_W-1:0] row0, exp_row;
        logic [3:0] nr;
        logic [1:0] pmp, rmp;
        if (bus.req0_vld && bus.req1_vld) w = (m_last == 1) ? 0 : 1;
        else w = bus.req0_vld ? 0 : 1;
        row0 = (w == 0) ? bus.req0_row : bus.req1_row;
        nr   = (w == 0) ? bus.req0_nrow : bus.req1_nrow;
        pmp  = bus.cfg_pump_opt;
        rmp  = bus.cfg_ramp_opt;
        #1;
        n = 0;
        while (!(bus.req0_ack || bus.req1_ack) && n < 8) begin
            step();
            #1;
            n++;
        end
        check("ack_lat", n, 0);
        check("ack0", int'(bus.req0_ack), (w == 0) ? 1 : 0);
        check("ack1", int'(bus.req1_ack), (w == 1) ? 1 : 0);
        m_last   = w;
        g        = cyc;
        c        = g;
        ended    = 1'b0;
        exp_err  = 0;
        exp_done = 0;
        step();
        if (w == 0) bus.req0_vld = 1'b0;
        else        bus.req1_vld = 1'b0;
        for (int k = 0; k <= int'(nr) && !ended; k++) begin
            n = 0;
            while (!bus.ee_wbusy_s && n < 60) begin
                bus.cfg_pump_opt = 2'($urandom_range(0, 3));
                bus.cfg_ramp_opt = 2'($urandom_range(0, 3));
                step();
                n++;
            end
            check("rise_cyc", cyc, (k == 0) ? g + SETUP_CYC + 1
                                            : c + RECOV_CYC + SETUP_CYC + 2);
            exp_row = row0 + ROW_W'(k);
            check("row",  int'(bus.ee_row), int'(exp_row));
            check("pump", int'(bus.ee_pump_opt), int'(pmp));
            check("ramp", int'(bus.ee_ramp_opt), int'(rmp));
            if (k == abort_row) begin
                repeat (abort_off) step();
                bus.abort = 1'b1;
                step();
                bus.abort = 1'b0;
                check("abort_drop", int'(bus.ee_wbusy_s), 0);
                exp_done = cyc;
                exp_err  = 1;
                ended    = 1'b1;
            end else if (k == tout_row) begin
                n = 0;
                while (bus.ee_wbusy_s && n < TOUT_CYC + 20) begin
                    step();
                    n++;
                end
                check("tout_len", n, TOUT_CYC);
                exp_done = cyc;
                exp_err  = 1;
                ended    = 1'b1;
            end else begin
                d = (wd_fix > 0) ? wd_fix : int'($urandom_range(1, 30));
                repeat (d) step();
                bus.ee_wdone = 1'b1;
                c = cyc;
                step();
                bus.ee_wdone = 1'b0;
                check("wd_drop", int'(bus.ee_wbusy_s), 0);
                if (k == rst_row) begin
                    // Pending trim request raised mid-operation, then a
                    // one-cycle reset while in the recovery gap.
                    bus.req1_vld  = 1'b1;
                    bus.req1_row  = ROW_W'(20);
                    bus.req1_nrow = 4'd0;
                    repeat (3) step();
                    sys_rst = 1'b1;
                    step();
                    sys_rst = 1'b0;
                    m_last  = 1;
                    #1;
                    check_quiet("mid_rst");
                    check("mid_rst_ack0", int'(bus.req0_ack), 0);
                    check("mid_rst_ack1", int'(bus.req1_ack), 1);
                    return;
                end
                exp_done = c + RECOV_CYC + 2;
            end
        end
        n = 0;
        while (!(bus.done0 || bus.done1) && n < 100) begin
            step();
            n++;
        end
        check("done_cyc", cyc, exp_done);
        check("done0", int'(bus.done0), (w == 0) ? 1 : 0);
        check("done1", int'(bus.done1), (w == 1) ? 1 : 0);
        check("err",   int'(bus.err), exp_err);
        step();
        check("busy_fall", int'(bus.busy), 0);
        check("err_idle",  int'(bus.err), 0);
        check("done_once", int'(bus.done0 || bus.done1), 0);
    endtask

    initial begin
        int sel, ab;
        bus.req0_vld     = 1'b0;
        bus.req0_row     = '0;
        bus.req0_nrow    = '0;
        bus.req1_vld     = 1'b0;
        bus.req1_row     = '0;
        bus.req1_nrow    = '0;
        bus.cfg_pump_opt = '0;
        bus.cfg_ramp_opt = '0;
        bus.abort        = 1'b0;
        bus.ee_wdone     = 1'b0;
        sys_rst          = 1'b1;
        do_reset();

        // Single-row SPI write, engine completes after 100 cycles.
        bus.req0_row = ROW_W'(5); bus.req0_nrow = 4'd0;
        bus.cfg_pump_opt = 2'd2;  bus.cfg_ramp_opt = 2'd1;
        bus.req0_vld = 1'b1;
        serve(100, -1, -1, 0, -1);

        // Three-row trim crossing the row wrap: 62, 63, 0.
        bus.req1_row = ROW_W'(62); bus.req1_nrow = 4'd2;
        bus.req1_vld = 1'b1;
        serve(0, -1, -1, 0, -1);

        // Tie after reset goes to req0; req0 re-requesting loses next.
        do_reset();
        bus.req0_row = ROW_W'(1);  bus.req0_nrow = 4'd0;
        bus.req1_row = ROW_W'(33); bus.req1_nrow = 4'd1;
        bus.req0_vld = 1'b1; bus.req1_vld = 1'b1;
        serve(0, -1, -1, 0, -1);
        bus.req0_row = ROW_W'(9); bus.req0_nrow = 4'd0;
        bus.req0_vld = 1'b1;
        serve(0, -1, -1, 0, -1);
        serve(0, -1, -1, 0, -1);

        // Hung program cycle, then a clean operation.
        bus.req0_row = ROW_W'(7); bus.req0_nrow = 4'd0;
        bus.req0_vld = 1'b1;
        serve(0, 0, -1, 0, -1);
        bus.req1_row = ROW_W'(3); bus.req1_nrow = 4'd1;
        bus.req1_vld = 1'b1;
        serve(0, -1, -1, 0, -1);

        // Abort three cycles into the first row of a four-row op.
        bus.req0_row = ROW_W'(30); bus.req0_nrow = 4'd3;
        bus.cfg_pump_opt = 2'd3;
        bus.req0_vld = 1'b1;
        serve(0, -1, 0, 3, -1);

        // Reset in the recovery gap, then the pending trim request.
        bus.req0_row = ROW_W'(40); bus.req0_nrow = 4'd1;
        bus.req0_vld = 1'b1;
        serve(0, -1, -1, 0, 0);
        serve(0, -1, -1, 0, -1);

        // Randomized operations, occasional aborts and ties.
        for (int it = 0; it < 25; it++) begin
            sel = int'($urandom_range(0, 2));
            if (sel != 1 && !bus.req0_vld) begin
                bus.req0_row  = ROW_W'($urandom_range(0, 63));
                bus.req0_nrow = 4'($urandom_range(0, 3));
                bus.req0_vld  = 1'b1;
            end
            if (sel != 0 && !bus.req1_vld) begin
                bus.req1_row  = ROW_W'($urandom_range(0, 63));
                bus.req1_nrow = 4'($urandom_range(0, 3));
                bus.req1_vld  = 1'b1;
            end
            bus.cfg_pump_opt = 2'($urandom_range(0, 3));
            bus.cfg_ramp_opt = 2'($urandom_range(0, 3));
            ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1)) : -1;
            serve(0, -1, ab, int'($urandom_range(0, 5)), -1);
        end
        while (bus.req0_vld || bus.req1_vld) serve(0, -1, -1, 0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
